// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word/opcode widths,
// the FSM state encoding and the opcode constants used by the control unit.
package instr_fetch_pkg;

  localparam int WORD_W = 16;
  localparam int OPC_W  = 4;

  // Opcode whose immediate is the following memory word.
  localparam logic [OPC_W-1:0] OPC_LONG = 4'hF;
  // Opcode whose immediate is the zero-extended low 12 bits of IR.
  localparam logic [OPC_W-1:0] OPC_JUMP = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXT   = 2'd2,
    DONE  = 2'd3
  } fetchState_e;

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcodeOf(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and the
// instruction memory (slave). Read data is valid in the cycle mem_ready is high.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [WORD_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/instr_fetch_imm_gen.sv
// Immediate decode for single-word instructions. Jumps take a zero-extended
// 12-bit target; everything else sign-extends the low byte. The long-immediate
// opcode is resolved by the fetch FSM from the extension word, not here.
module instr_fetch_imm_gen
  import instr_fetch_pkg::*;
(
  input  logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] imm
);

  // Select the immediate form from the opcode field.
  always_comb begin
    imm = {WORD_W{1'b0}};
    if (opcodeOf(instr) == OPC_JUMP) begin
      imm = {4'b0000, instr[11:0]};
    end else begin
      imm = {{8{instr[7]}}, instr[7:0]};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Reads the word at PC, latches IR and the decoded
// immediate, and strobes pc_advance for every accepted memory word so pcs
// steps PC; a long-immediate instruction therefore sees the advanced PC in EXT.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              flush,
  input  logic [WORD_W-1:0] PC,
  instr_fetch_if.master     mem,
  output logic              pc_advance,
  output logic [WORD_W-1:0] IR,
  output logic [OPC_W-1:0]  opcode,
  output logic [WORD_W-1:0] ImR,
  output logic              ir_valid,
  output logic              busy
);

  fetchState_e       state_r;
  fetchState_e       nextState_s;
  logic [WORD_W-1:0] instr_r;
  logic [WORD_W-1:0] imm_r;
  logic              irValid_r;
  logic [WORD_W-1:0] immShort_s;
  logic              loadIr_s;
  logic              loadImmShort_s;
  logic              loadImmExt_s;
  logic              memRd_s;

  instr_fetch_imm_gen uImmGen (
    .instr (mem.mem_rdata),
    .imm   (immShort_s)
  );

  // Memory access is active only while fetching the opcode or extension word.
  always_comb begin
    memRd_s = 1'b0;
    if ((state_r == FETCH) || (state_r == EXT)) begin
      memRd_s = 1'b1;
    end else begin
      memRd_s = 1'b0;
    end
  end

  // A word is consumed only when it is accepted and not being discarded;
  // reset also suppresses the strobe so pcs never steps during reset.
  assign pc_advance   = memRd_s & mem.mem_ready & ~flush & ~reset;
  assign mem.mem_rd   = memRd_s;
  assign mem.mem_addr = memRd_s ? PC : {WORD_W{1'b0}};
  assign busy         = memRd_s;

  assign IR       = instr_r;
  assign opcode   = opcodeOf(instr_r);
  assign ImR      = imm_r;
  assign ir_valid = irValid_r;

  // Next-state and load-enable decode; flush overrides every other request.
  always_comb begin
    nextState_s    = state_r;
    loadIr_s       = 1'b0;
    loadImmShort_s = 1'b0;
    loadImmExt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (fetch_start) begin
          nextState_s = FETCH;
        end else begin
          nextState_s = IDLE;
        end
      end
      FETCH: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (mem.mem_ready) begin
          loadIr_s = 1'b1;
          if (opcodeOf(mem.mem_rdata) == OPC_LONG) begin
            nextState_s = EXT;
          end else begin
            loadImmShort_s = 1'b1;
            nextState_s    = DONE;
          end
        end else begin
          nextState_s = FETCH;
        end
      end
      EXT: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (mem.mem_ready) begin
          loadImmExt_s = 1'b1;
          nextState_s  = DONE;
        end else begin
          nextState_s = EXT;
        end
      end
      DONE: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (fetch_start) begin
          nextState_s = FETCH;
        end else begin
          nextState_s = DONE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, instruction and immediate registers; IR/ImR persist across flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      instr_r   <= {WORD_W{1'b0}};
      imm_r     <= {WORD_W{1'b0}};
      irValid_r <= 1'b0;
    end else begin
      state_r <= nextState_s;
      if (loadIr_s) begin
        instr_r <= mem.mem_rdata;
      end
      if (loadImmShort_s) begin
        imm_r <= immShort_s;
      end else if (loadImmExt_s) begin
        imm_r <= mem.mem_rdata;
      end
      irValid_r <= (nextState_s == DONE);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. A small pcs model steps PC on every
// pc_advance strobe; memory data and ready are driven per cycle by each test.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchStart;
  logic        flush;
  logic [15:0] pcBase;
  int          advTotal = 0;
  int          advStart;
  logic [15:0] pc;
  logic        pcAdvance;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [15:0] imm;
  logic        irValid;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  logic [15:0] jumpWord [2] = '{16'hE016, 16'hE15D};
  logic [15:0] jumpImm  [2] = '{16'h0016, 16'h015D};

  instr_fetch_if memBus ();

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetchStart),
    .flush       (flush),
    .PC          (pc),
    .mem         (memBus),
    .pc_advance  (pcAdvance),
    .IR          (ir),
    .opcode      (opcode),
    .ImR         (imm),
    .ir_valid    (irValid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // pcs model: PC steps by one per advance strobe since the test set its base.
  always @(posedge clk) begin
    if (pcAdvance === 1'b1) advTotal <= advTotal + 1;
  end
  assign pc = pcBase + 16'(advTotal - advStart);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetchStart = 1'b0; flush = 1'b0; pcBase = 16'h0000; advStart = 0;
    memBus.mem_ready = 1'b0; memBus.mem_rdata = 16'h0000;
    tick(); tick();
    total++; if (memBus.mem_rd !== 1'b0 || memBus.mem_addr !== 16'h0000 || busy !== 1'b0)
      begin bad++; $display("FAIL reset_bus: rd=%b addr=%h busy=%b want 0/0000/0", memBus.mem_rd, memBus.mem_addr, busy); end
    total++; if (ir !== 16'h0000 || imm !== 16'h0000 || irValid !== 1'b0)
      begin bad++; $display("FAIL reset_regs: IR=%h ImR=%h valid=%b want 0000/0000/0", ir, imm, irValid); end
    // reset asserted mid-FETCH while memory stalls, then returns data
    reset = 1'b0; advStart = advTotal; pcBase = 16'h0008; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0; #1;
    total++; if (memBus.mem_rd !== 1'b1 || memBus.mem_addr !== 16'h0008)
      begin bad++; $display("FAIL reset_prefetch: rd=%b addr=%h want 1/0008", memBus.mem_rd, memBus.mem_addr); end
    reset = 1'b1; memBus.mem_ready = 1'b1; memBus.mem_rdata = 16'hF234; #1;
    total++; if (pcAdvance !== 1'b0)
      begin bad++; $display("FAIL reset_noadv: pc_advance=%b want 0", pcAdvance); end
    tick(); tick();
    total++; if (memBus.mem_rd !== 1'b0 || irValid !== 1'b0 || ir !== 16'h0000 || imm !== 16'h0000)
      begin bad++; $display("FAIL reset_midfetch: rd=%b valid=%b IR=%h ImR=%h want 0/0/0000/0000", memBus.mem_rd, irValid, ir, imm); end
    total++; if (advTotal - advStart !== 0)
      begin bad++; $display("FAIL reset_advcount: got %0d want 0", advTotal - advStart); end
    reset = 1'b0; memBus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_short();
    pcBase = 16'h0005; advStart = advTotal;
    memBus.mem_rdata = 16'h30FE; memBus.mem_ready = 1'b1; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0; #1;
    total++; if (memBus.mem_addr !== 16'h0005 || pcAdvance !== 1'b1 || irValid !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL short_fetch: addr=%h adv=%b valid=%b busy=%b want 0005/1/0/1", memBus.mem_addr, pcAdvance, irValid, busy); end
    tick();
    total++; if (ir !== 16'h30FE || imm !== 16'hFFFE || opcode !== 4'h3 || irValid !== 1'b1)
      begin bad++; $display("FAIL short_result: IR=%h ImR=%h op=%h valid=%b want 30FE/FFFE/3/1", ir, imm, opcode, irValid); end
    total++; if (memBus.mem_rd !== 1'b0 || pcAdvance !== 1'b0)
      begin bad++; $display("FAIL short_done_bus: rd=%b adv=%b want 0/0", memBus.mem_rd, pcAdvance); end
    tick();
    total++; if (irValid !== 1'b1 || advTotal - advStart !== 1)
      begin bad++; $display("FAIL short_hold: valid=%b adv=%0d want 1/1", irValid, advTotal - advStart); end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 2; i++) begin
      pcBase = 16'h0100; advStart = advTotal;
      memBus.mem_rdata = jumpWord[i]; memBus.mem_ready = 1'b1; fetchStart = 1'b1;
      tick();
      fetchStart = 1'b0; #1;
      total++; if (irValid !== 1'b0)
        begin bad++; $display("FAIL jump_clear_%0d: valid=%b want 0", i, irValid); end
      tick();
      total++; if (ir !== jumpWord[i] || imm !== jumpImm[i] || opcode !== 4'hE || irValid !== 1'b1)
        begin bad++; $display("FAIL jump_%0d: IR=%h ImR=%h op=%h valid=%b want %h/%h/e/1", i, ir, imm, opcode, irValid, jumpWord[i], jumpImm[i]); end
    end
  endtask

  task automatic test_long();
    pcBase = 16'h0010; advStart = advTotal;
    memBus.mem_rdata = 16'hF000; memBus.mem_ready = 1'b1; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0; #1;
    total++; if (memBus.mem_addr !== 16'h0010 || pcAdvance !== 1'b1)
      begin bad++; $display("FAIL long_first: addr=%h adv=%b want 0010/1", memBus.mem_addr, pcAdvance); end
    tick();
    memBus.mem_rdata = 16'h1000; #1;
    total++; if (memBus.mem_addr !== 16'h0011 || pcAdvance !== 1'b1 || irValid !== 1'b0 || ir !== 16'hF000)
      begin bad++; $display("FAIL long_ext: addr=%h adv=%b valid=%b IR=%h want 0011/1/0/F000", memBus.mem_addr, pcAdvance, irValid, ir); end
    tick();
    total++; if (ir !== 16'hF000 || imm !== 16'h1000 || irValid !== 1'b1 || opcode !== 4'hF)
      begin bad++; $display("FAIL long_result: IR=%h ImR=%h valid=%b op=%h want F000/1000/1/f", ir, imm, irValid, opcode); end
    total++; if (advTotal - advStart !== 2)
      begin bad++; $display("FAIL long_advcount: got %0d want 2", advTotal - advStart); end
  endtask

  task automatic test_wait_flush();
    pcBase = 16'h0020; advStart = advTotal;
    memBus.mem_ready = 1'b0; memBus.mem_rdata = 16'h1111; fetchStart = 1'b1;
    tick();
    for (int w = 0; w < 3; w++) begin
      #1;
      total++; if (memBus.mem_addr !== 16'h0020 || pcAdvance !== 1'b0 || busy !== 1'b1)
        begin bad++; $display("FAIL wait_%0d: addr=%h adv=%b busy=%b want 0020/0/1", w, memBus.mem_addr, pcAdvance, busy); end
      tick();
    end
    fetchStart = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    total++; if (busy !== 1'b0 || irValid !== 1'b0 || ir !== 16'hF000 || imm !== 16'h1000 || advTotal - advStart !== 0)
      begin bad++; $display("FAIL wait_flush: busy=%b valid=%b IR=%h ImR=%h adv=%0d want 0/0/F000/1000/0", busy, irValid, ir, imm, advTotal - advStart); end
    // long fetch aborted while the extension word is being returned
    pcBase = 16'h0030; advStart = advTotal;
    memBus.mem_ready = 1'b1; memBus.mem_rdata = 16'hF123; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    tick();
    memBus.mem_rdata = 16'h5555; flush = 1'b1; #1;
    total++; if (pcAdvance !== 1'b0 || memBus.mem_addr !== 16'h0031)
      begin bad++; $display("FAIL ext_flush_adv: adv=%b addr=%h want 0/0031", pcAdvance, memBus.mem_addr); end
    tick();
    flush = 1'b0; memBus.mem_ready = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || irValid !== 1'b0 || ir !== 16'hF123 || imm !== 16'h1000 || advTotal - advStart !== 1)
      begin bad++; $display("FAIL ext_flush: busy=%b valid=%b IR=%h ImR=%h adv=%0d want 0/0/F123/1000/1", busy, irValid, ir, imm, advTotal - advStart); end
  endtask

  task automatic test_flush_ready();
    pcBase = 16'h0040; advStart = advTotal;
    memBus.mem_ready = 1'b0; memBus.mem_rdata = 16'h2A7F; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0; memBus.mem_ready = 1'b1; flush = 1'b1; #1;
    total++; if (pcAdvance !== 1'b0)
      begin bad++; $display("FAIL flushready_adv: adv=%b want 0", pcAdvance); end
    tick();
    flush = 1'b0; #1;
    total++; if (ir !== 16'hF123 || busy !== 1'b0 || irValid !== 1'b0 || advTotal - advStart !== 0)
      begin bad++; $display("FAIL flushready_discard: IR=%h busy=%b valid=%b adv=%0d want F123/0/0/0", ir, busy, irValid, advTotal - advStart); end
    fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    tick();
    total++; if (ir !== 16'h2A7F || imm !== 16'h007F || irValid !== 1'b1 || advTotal - advStart !== 1)
      begin bad++; $display("FAIL refetch: IR=%h ImR=%h valid=%b adv=%0d want 2A7F/007F/1/1", ir, imm, irValid, advTotal - advStart); end
    // flush and fetch_start together in DONE: flush wins
    flush = 1'b1; fetchStart = 1'b1;
    tick();
    flush = 1'b0; fetchStart = 1'b0; #1;
    total++; if (irValid !== 1'b0 || busy !== 1'b0 || ir !== 16'h2A7F)
      begin bad++; $display("FAIL flush_start: valid=%b busy=%b IR=%h want 0/0/2A7F", irValid, busy, ir); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_jump();
    test_long();
    test_wait_flush();
    test_flush_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
